// File: rtl/core_sequencer.sv
// core_sequencer -- control sequencer for a small bracket-language core.
//
// The sequencer arbitrates between normal execution (CORE_S), a forward
// bracket scan that skips a loop body (BRANCH_S), a fixed-length stall
// (STALL_S) and a terminal error state (HALT_S).
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   rst_n        : synchronous active-low reset
//   next_state   : state requested by core control for the current PC
//   instruction  : opcode fetched at the current PC
//   fetch_valid  : instruction is valid this cycle
//   prog_end     : the current PC is past the last program word
//   state        : current sequencer state
//   core_enable  : core write enables / pc_write honoured this cycle
//   scan_pc_inc  : PC advances this cycle on behalf of the bracket scan
//   depth        : current bracket-nesting depth
//   error        : sticky depth-overflow / unmatched-bracket flag

package core_sequencer_pkg;

  typedef enum logic [1:0] {
    CORE_S   = 2'd0,
    BRANCH_S = 2'd1,
    STALL_S  = 2'd2,
    HALT_S   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    INC = 3'd0,
    DEC = 3'd1,
    MVR = 3'd2,
    MVL = 3'd3,
    OUT = 3'd4,
    INP = 3'd5,
    CBF = 3'd6,
    CBB = 3'd7
  } op_code_t;

endpackage

module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int DEPTH_W      = 8,
  parameter int STALL_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         next_state,
  input  op_code_t           instruction,
  input  logic               fetch_valid,
  input  logic               prog_end,
  output logic [1:0]         state,
  output logic               core_enable,
  output logic               scan_pc_inc,
  output logic [DEPTH_W-1:0] depth,
  output logic               error
);

  // The stall counter holds STALL_CYCLES-1 at most; keep it at least 1 bit.
  localparam int CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   STALL_LOAD = CNT_W'(STALL_CYCLES - 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               error_q, error_d;

  // Next-state, depth, stall-count and error computation.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    stall_cnt_d = stall_cnt_q;
    error_d     = error_q;
    case (state_q)
      CORE_S: begin
        depth_d = '0;
        if (fetch_valid) begin
          case (next_state)
            BRANCH_S: begin
              state_d = BRANCH_S;
              depth_d = DEPTH_ONE;
            end
            STALL_S: begin
              state_d     = STALL_S;
              stall_cnt_d = STALL_LOAD;
            end
            // CORE_S and the unused encoding both keep executing.
            default: state_d = CORE_S;
          endcase
        end else begin
          state_d = CORE_S;
        end
      end
      STALL_S: begin
        depth_d = '0;
        if (stall_cnt_q != '0) begin
          stall_cnt_d = stall_cnt_q - CNT_W'(1);
        end else begin
          state_d = CORE_S;
        end
      end
      BRANCH_S: begin
        // Running off the program end wins over whatever was fetched.
        if (prog_end) begin
          error_d = 1'b1;
          state_d = HALT_S;
        end else if (fetch_valid) begin
          if (instruction == CBF) begin
            // Saturate rather than wrap: a wrapped depth would mis-match.
            if (depth_q == DEPTH_MAX) begin
              error_d = 1'b1;
              state_d = HALT_S;
            end else begin
              depth_d = depth_q + DEPTH_ONE;
            end
          end else if (instruction == CBB) begin
            depth_d = depth_q - DEPTH_ONE;
            if (depth_q == DEPTH_ONE) begin
              state_d = CORE_S;
            end else begin
              state_d = BRANCH_S;
            end
          end else begin
            depth_d = depth_q;
          end
        end else begin
          depth_d = depth_q;
        end
      end
      HALT_S: begin
        // Only reset leaves HALT_S; depth keeps its value at entry.
        state_d = HALT_S;
      end
      default: begin
        state_d = CORE_S;
        depth_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CORE_S;
      depth_q     <= '0;
      stall_cnt_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      stall_cnt_q <= stall_cnt_d;
      error_q     <= error_d;
    end
  end

  assign state = state_q;
  assign depth = depth_q;
  assign error = error_q;

  // Enables qualify registered state with this cycle's fetch; forced low
  // while reset is being sampled.
  assign core_enable = rst_n && (state_q == CORE_S)   && fetch_valid;
  assign scan_pc_inc = rst_n && (state_q == BRANCH_S) && fetch_valid;

endmodule
